// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a length-prefixed byte stream into big-endian
// 32-bit imem writes from address 0, holding the CPU in reset until a clean load.
module imem_loader #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);
    localparam int unsigned DEPTH = 2**ADDR_W;

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DRAIN, DONE} state_t;

    state_t          state, state_nx;
    logic [15:0]     len;
    logic [ADDR_W:0] idx;
    logic [1:0]      byte_cnt;
    logic [31:0]     shreg;
    logic [17:0]     drain_cnt;
    logic            err_q;

    logic            accept;
    logic [15:0]     len_nx;
    logic [ADDR_W:0] idx_inc;

    assign accept  = in_valid & in_ready;
    assign len_nx  = {len[15:8], in_data};
    assign idx_inc = idx + 1'b1;

    assign imem_addr = idx[ADDR_W-1:0];
    assign imem_wd   = shreg;
    assign err       = err_q;
    assign cpu_hold  = ~(done & ~err_q);

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        imem_we  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) state_nx = LEN_HI;
            end
            LEN_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept) state_nx = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    if (len_nx == 16'd0)            state_nx = DONE;
                    else if (32'(len_nx) > DEPTH)  state_nx = DRAIN;
                    else                           state_nx = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && byte_cnt == 2'd3) state_nx = WRITE;
            end
            WRITE: begin
                imem_we  = 1'b1;
                busy     = 1'b1;
                // idx is one bit wider than the address so N == DEPTH terminates
                state_nx = (32'(idx_inc) == 32'(len)) ? DONE : DATA;
            end
            DRAIN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && drain_cnt == 18'd1) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            len       <= '0;
            idx       <= '0;
            byte_cnt  <= '0;
            shreg     <= '0;
            drain_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_q    <= 1'b0;
                        idx      <= '0;
                        byte_cnt <= '0;
                    end
                end
                LEN_HI: if (accept) len[15:8] <= in_data;
                LEN_LO: begin
                    if (accept) begin
                        len[7:0]  <= in_data;
                        drain_cnt <= {len_nx, 2'b00};
                        if (32'(len_nx) > DEPTH) err_q <= 1'b1;
                    end
                end
                DATA: begin
                    if (accept) begin
                        // ~byte_cnt == 3-byte_cnt: first byte lands in [31:24]
                        shreg[{~byte_cnt, 3'b000} +: 8] <= in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                WRITE: idx <= idx_inc;
                DRAIN: if (accept) drain_cnt <= drain_cnt - 18'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-stream driver, write/handshake monitor,
// hand-computed expectations for each load scenario.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, imem_we, busy, done, err, cpu_hold;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wd;

    imem_loader #(.ADDR_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
        .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  src_q[$];
    logic [5:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          wr_rdy_viol = 0;
    int          hold_fall_cyc = -1;
    logic        hold_prev = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wd);
            wr_cyc.push_back(cyc);
            if (in_ready) wr_rdy_viol++;
        end
        if (in_valid && in_ready) acc_cnt++;
        if (hold_prev && !cpu_hold) hold_fall_cyc = cyc;
        hold_prev = cpu_hold;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        src_q.delete();
        acc_cnt = 0;
        wr_rdy_viol = 0;
        hold_fall_cyc = -1;
    endtask

    task automatic push_len(input logic [15:0] n);
        src_q.push_back(n[15:8]);
        src_q.push_back(n[7:0]);
    endtask

    task automatic push_word(input logic [31:0] w);
        src_q.push_back(w[31:24]);
        src_q.push_back(w[23:16]);
        src_q.push_back(w[15:8]);
        src_q.push_back(w[7:0]);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Drives src_q; a byte is popped only when the DUT accepted it.
    task automatic feed(input string tag, input bit toggle, input bit until_done, input int budget);
        int n = 0;
        bit ph = 1'b1;
        bit acc;
        while ((until_done ? !done : (src_q.size() > 0)) && n < budget) begin
            in_valid = (src_q.size() > 0) && (!toggle || ph);
            in_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) void'(src_q.pop_front());
            ph = !ph;
            n++;
        end
        in_valid = 1'b0;
        check({tag, "_in_time"}, 32'(n < budget), 32'd1);
    endtask

    function automatic logic [31:0] big_word(input int i);
        return {8'(i), 8'hC3, 8'(255 - i), 8'(i * 7)};
    endfunction

    task automatic load_a(input string tag, input bit toggle);
        clear_mon();
        push_len(16'd2);
        push_word(32'h20080005);
        push_word(32'hAC080004);
        pulse_start();
        feed(tag, toggle, 1'b1, 200);
        @(negedge clk); #1;
        check({tag, "_nwr"}, wr_data.size(), 2);
        if (wr_data.size() == 2) begin
            check({tag, "_a0"}, 32'(wr_addr[0]), 0);
            check({tag, "_d0"}, wr_data[0], 32'h20080005);
            check({tag, "_a1"}, 32'(wr_addr[1]), 1);
            check({tag, "_d1"}, wr_data[1], 32'hAC080004);
            if (!toggle) check({tag, "_gap"}, wr_cyc[1] - wr_cyc[0], 5);
            check({tag, "_hold_fall"}, hold_fall_cyc, wr_cyc[1] + 1);
        end
        check({tag, "_acc"}, acc_cnt, 10);
        check({tag, "_rdy_wr"}, wr_rdy_viol, 0);
        check({tag, "_done"}, done, 1);
        check({tag, "_err"}, err, 0);
        check({tag, "_hold"}, cpu_hold, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_wd", imem_wd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_hold", cpu_hold, 1);
        @(negedge clk) reset_n = 1'b1;

        load_a("seq", 1'b0);
        load_a("tog", 1'b1);

        clear_mon();
        push_len(16'd0);
        pulse_start();
        feed("zero", 1'b0, 1'b1, 50);
        @(negedge clk); #1;
        check("zero_nwr", wr_data.size(), 0);
        check("zero_acc", acc_cnt, 2);
        check("zero_done", done, 1);
        check("zero_err", err, 0);
        check("zero_hold", cpu_hold, 0);

        clear_mon();
        push_len(16'h0041);
        for (int i = 0; i < 261; i++) src_q.push_back(8'(i));
        pulse_start();
        feed("ovf", 1'b0, 1'b1, 1000);
        @(negedge clk); #1;
        check("ovf_nwr", wr_data.size(), 0);
        check("ovf_acc", acc_cnt, 262);
        check("ovf_left", src_q.size(), 1);
        check("ovf_done", done, 1);
        check("ovf_err", err, 1);
        check("ovf_hold", cpu_hold, 1);

        clear_mon();
        push_len(16'h0040);
        for (int i = 0; i < 64; i++) push_word(big_word(i));
        pulse_start();
        feed("full", 1'b0, 1'b1, 1000);
        @(negedge clk); #1;
        check("full_nwr", wr_data.size(), 64);
        if (wr_data.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                check($sformatf("full_a%0d", i), 32'(wr_addr[i]), 32'(i));
                check($sformatf("full_d%0d", i), wr_data[i], big_word(i));
            end
        end
        check("full_done", done, 1);
        check("full_err", err, 0);
        check("full_hold", cpu_hold, 0);

        clear_mon();
        push_len(16'd1);
        src_q.push_back(8'h20);
        src_q.push_back(8'h08);
        pulse_start();
        feed("mid", 1'b0, 1'b0, 50);
        check("mid_busy_pre", busy, 1);
        check("mid_ready_pre", in_ready, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_ready", in_ready, 0);
        check("mid_we", imem_we, 0);
        check("mid_addr", 32'(imem_addr), 0);
        check("mid_wd", imem_wd, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_err", err, 0);
        check("mid_hold", cpu_hold, 1);
        @(negedge clk) reset_n = 1'b1;
        load_a("post", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: accepts a byte stream carrying a length header and program words, packs the bytes into 32-bit big-endian MIPS instructions, and writes them into instruction memory at consecutive word addresses starting at 0.
- Holds the processor in reset until a program loads cleanly, so fetch never sees a partial image.
- Sits between the host byte channel and the imem write port, next to the MIPS top level.

Parameters:
- ADDR_W, 6, imem word-address width; DEPTH = 2**ADDR_W words (64 by default).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load; honoured only in IDLE or DONE.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  byte-stream ready; a byte transfers when in_valid & in_ready.
- imem_we  output  1  imem write enable, one-cycle pulse per word.
- imem_addr  output  ADDR_W  imem word address.
- imem_wd  output  32  imem write data.
- busy  output  1  load in progress (states LEN_HI through WRITE, and DRAIN).
- done  output  1  load finished; held until the next accepted start.
- err  output  1  length exceeded DEPTH; valid while done=1.
- cpu_hold  output  1  processor reset request; 1 unless done=1 and err=0.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - in_ready=0, imem_we=0, imem_addr=0, imem_wd=0.
  - busy=0, done=0, err=0, cpu_hold=1.
  - Byte, length and word-index registers cleared.
  - Reset mid-load abandons the load; imem contents are left as partially written.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DRAIN, DONE.
- IDLE/DONE:
  - in_ready=0.
  - start=1 moves to LEN_HI next cycle and clears done, err, word index and byte count.
  - start in any other state is ignored.
- LEN_HI: in_ready=1; an accepted byte becomes N[15:8]; go to LEN_LO.
- LEN_LO: in_ready=1; an accepted byte becomes N[7:0]; then:
  - N==0: go to DONE with err=0.
  - N>DEPTH: go to DRAIN with err=1.
  - Otherwise: go to DATA.
- DATA:
  - in_ready=1; bytes arrive MSB first. Byte k (k=0..3) of the word lands in bits [31-8k -: 8] of the shift register.
  - The 4th accepted byte moves to WRITE.
  - A stalled in_valid holds the state indefinitely with no timeout.
- WRITE (exactly one cycle):
  - in_ready=0, imem_we=1, imem_addr=word index, imem_wd=assembled word.
  - Next cycle: word index increments. If the new index equals N, go to DONE; otherwise go to DATA.
  - Consequence: a sustained stream costs 5 cycles per word.
- DRAIN:
  - in_ready=1; accepts and discards exactly 4*N bytes (18-bit counter); imem_we stays 0.
  - Then go to DONE; err stays 1.
- DONE:
  - done=1.
  - cpu_hold=0 if err=0, else cpu_hold stays 1.
- imem_addr and imem_wd are don't-care when imem_we=0 but must not be X after reset.
- N==DEPTH is legal: the final word is written to address DEPTH-1, and the index register must not wrap before the N comparison (index is ADDR_W+1 bits wide).
- Bytes presented while in_ready=0 are not consumed; the source holds them.
- start and in_valid arriving in the same cycle in IDLE: the byte is not consumed in that cycle.

Test Plan:
- Reset, start, bytes 00 02 | 20 08 00 05 | AC 08 00 04, in_valid held 1 → two imem_we pulses: addr 0 = 0x20080005, addr 1 = 0xAC080004, 5 cycles apart. Then done=1, err=0, cpu_hold drops to 0 the cycle after the second write.
- Same stream with in_valid toggled 1/0 on alternate cycles → identical writes; no byte lost or duplicated; in_ready=0 on each WRITE cycle.
- Length 00 00 → DONE directly after LEN_LO; no imem_we; done=1, cpu_hold=0.
- Length 00 41 (65 > 64), then 260 bytes → no imem_we; in_ready=1 for exactly 260 accepted bytes; then done=1, err=1, cpu_hold=1.
- Length 00 40 with 64 words → last write at addr 63; done=1, err=0.
- Assert reset_n=0 after 2 of 4 data bytes → outputs return to reset values asynchronously. A fresh start and a full load then succeed from addr 0.
